// File: rtl/csr_trap_sequencer_pkg.sv
// Shared encodings, CSR addresses, FSM states and the storage request
// payload for csr_trap_sequencer.
package csr_trap_sequencer_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned ADDR_W = 12;
    localparam int unsigned CMD_W  = 3;

    // Pipeline CSR command encodings
    localparam logic [CMD_W-1:0] CSR_X = 3'd0;
    localparam logic [CMD_W-1:0] CSR_W = 3'd1;
    localparam logic [CMD_W-1:0] CSR_S = 3'd2;
    localparam logic [CMD_W-1:0] CSR_C = 3'd3;
    localparam logic [CMD_W-1:0] CSR_E = 3'd4;

    // Machine-mode CSR addresses owned by the sequencer
    localparam logic [ADDR_W-1:0] ADDR_MTVEC   = 12'h305;
    localparam logic [ADDR_W-1:0] ADDR_MEPC    = 12'h341;
    localparam logic [ADDR_W-1:0] ADDR_MCAUSE  = 12'h342;
    localparam logic [ADDR_W-1:0] ADDR_MSTATUS = 12'h300;

    // mstatus interrupt-enable bit positions
    localparam int unsigned MSTATUS_MIE  = 3;
    localparam int unsigned MSTATUS_MPIE = 7;

    typedef enum logic [3:0] {
        S_IDLE,
        S_P_RD,
        S_P_WR,
        S_T_EPC,
        S_T_CAUSE,
        S_T_VEC_RD,
        S_T_VEC_WT,
        S_R_EPC_RD,
        S_R_EPC_WT,
        S_REDIR,
        S_T_ST_RD,
        S_T_ST_WT,
        S_T_ST_WR
    } state_t;

    // One cycle of CSR storage port activity
    typedef struct packed {
        logic              en;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [XLEN-1:0]   wdata;
    } csr_req_t;

    // Force a PC to a 4-byte boundary
    function automatic logic [XLEN-1:0] align4(input logic [XLEN-1:0] a);
        return {a[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/csr_trap_sequencer_if.sv
// Bundle of pipeline CSR, trap/mret, redirect and CSR storage signals.
// slave = sequencer side, master = pipeline + storage side.
interface csr_trap_sequencer_if;
    import csr_trap_sequencer_pkg::*;

    logic              pipe_csr_valid;
    logic [CMD_W-1:0]  pipe_csr_cmd;
    logic [ADDR_W-1:0] pipe_csr_addr;
    logic [XLEN-1:0]   pipe_csr_op1;
    logic              pipe_csr_done;
    logic [XLEN-1:0]   pipe_csr_rdata;

    logic              trap_req;
    logic [XLEN-1:0]   trap_cause;
    logic [XLEN-1:0]   trap_pc;
    logic              mret_req;

    logic              busy;
    logic              redirect_valid;
    logic [XLEN-1:0]   redirect_pc;

    logic              csr_en;
    logic              csr_we;
    logic [ADDR_W-1:0] csr_addr;
    logic [XLEN-1:0]   csr_wdata;
    logic [XLEN-1:0]   csr_rdata;

    modport slave (
        input  pipe_csr_valid, pipe_csr_cmd, pipe_csr_addr, pipe_csr_op1,
        output pipe_csr_done, pipe_csr_rdata,
        input  trap_req, trap_cause, trap_pc, mret_req,
        output busy, redirect_valid, redirect_pc,
        output csr_en, csr_we, csr_addr, csr_wdata,
        input  csr_rdata
    );

    modport master (
        output pipe_csr_valid, pipe_csr_cmd, pipe_csr_addr, pipe_csr_op1,
        input  pipe_csr_done, pipe_csr_rdata,
        output trap_req, trap_cause, trap_pc, mret_req,
        input  busy, redirect_valid, redirect_pc,
        input  csr_en, csr_we, csr_addr, csr_wdata,
        output csr_rdata
    );

endinterface

// File: rtl/csr_trap_sequencer_csr_rmw_alu.sv
// CSR read-modify-write combiner: (cmd, old, op1) -> new value.
// Unknown commands return the old value unchanged.
module csr_trap_sequencer_csr_rmw_alu
    import csr_trap_sequencer_pkg::*;
(
    input  logic [CMD_W-1:0] i_cmd,
    input  logic [XLEN-1:0]  i_old,
    input  logic [XLEN-1:0]  i_op1,
    output logic [XLEN-1:0]  o_new_c
);

    // Select write / set / clear
    always_comb begin
        o_new_c = i_old;
        case (i_cmd)
            CSR_W:   o_new_c = i_op1;
            CSR_S:   o_new_c = i_old | i_op1;
            CSR_C:   o_new_c = i_old & ~i_op1;
            default: o_new_c = i_old;
        endcase
    end

endmodule

// File: rtl/csr_trap_sequencer.sv
// csr_trap_sequencer: sole owner of the CSR storage port. Serves pipeline
// CSR read-modify-write ops and sequences trap entry and mret, stalling the
// pipeline with busy and issuing a one-cycle PC redirect.
// Optional feature macro: MSTATUS_UPDATE_EN (adds mstatus MIE/MPIE update
// to trap entry and mret).
module csr_trap_sequencer
    import csr_trap_sequencer_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    csr_trap_sequencer_if.slave  bus
);

    state_t          r_state;
    state_t          w_next;
    csr_req_t        w_req;
    logic            w_done_nxt;
    logic            w_take_x;
    logic            w_pipe_rmw;
    logic [XLEN-1:0] w_alu_new;

    logic            r_done;
    logic [XLEN-1:0] r_pipe_rdata;
    logic [XLEN-1:0] r_redirect_pc;
    logic            r_redirect_valid;

`ifdef MSTATUS_UPDATE_EN
    logic            r_is_trap;
    logic [XLEN-1:0] r_mstatus;
    logic [XLEN-1:0] w_mstatus_new;
`endif

    assign w_pipe_rmw = (bus.pipe_csr_cmd == CSR_W) ||
                        (bus.pipe_csr_cmd == CSR_S) ||
                        (bus.pipe_csr_cmd == CSR_C);

    csr_trap_sequencer_csr_rmw_alu u_rmw_alu (
        .i_cmd   (bus.pipe_csr_cmd),
        .i_old   (bus.csr_rdata),
        .i_op1   (bus.pipe_csr_op1),
        .o_new_c (w_alu_new)
    );

`ifdef MSTATUS_UPDATE_EN
    // Trap stacks MIE into MPIE and disables; mret restores MIE and sets MPIE
    always_comb begin
        w_mstatus_new = r_mstatus;
        if (r_is_trap) begin
            w_mstatus_new[MSTATUS_MPIE] = r_mstatus[MSTATUS_MIE];
            w_mstatus_new[MSTATUS_MIE]  = 1'b0;
        end else begin
            w_mstatus_new[MSTATUS_MIE]  = r_mstatus[MSTATUS_MPIE];
            w_mstatus_new[MSTATUS_MPIE] = 1'b1;
        end
    end
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state, storage port request and done scheduling
    always_comb begin
        w_next     = r_state;
        w_req      = '0;
        w_done_nxt = 1'b0;
        w_take_x   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.trap_req) begin
                    w_next = S_T_EPC;
                end else if (bus.mret_req) begin
                    w_next = S_R_EPC_RD;
                end else if (bus.pipe_csr_valid && !r_done) begin
                    // r_done blocks re-accepting an op whose done is visible now
                    if (w_pipe_rmw) begin
                        w_next = S_P_RD;
                    end else begin
                        w_done_nxt = 1'b1;
                        w_take_x   = 1'b1;
                    end
                end
            end
            S_P_RD: begin
                w_req.en   = 1'b1;
                w_req.addr = bus.pipe_csr_addr;
                w_done_nxt = 1'b1;
                w_next     = S_P_WR;
            end
            S_P_WR: begin
                w_req.en    = 1'b1;
                w_req.we    = 1'b1;
                w_req.addr  = bus.pipe_csr_addr;
                w_req.wdata = w_alu_new;
                w_next      = S_IDLE;
            end
            S_T_EPC: begin
                w_req.en    = 1'b1;
                w_req.we    = 1'b1;
                w_req.addr  = ADDR_MEPC;
                w_req.wdata = align4(bus.trap_pc);
                w_next      = S_T_CAUSE;
            end
            S_T_CAUSE: begin
                w_req.en    = 1'b1;
                w_req.we    = 1'b1;
                w_req.addr  = ADDR_MCAUSE;
                w_req.wdata = bus.trap_cause;
`ifdef MSTATUS_UPDATE_EN
                w_next      = S_T_ST_RD;
`else
                w_next      = S_T_VEC_RD;
`endif
            end
            S_T_VEC_RD: begin
                w_req.en   = 1'b1;
                w_req.addr = ADDR_MTVEC;
                w_next     = S_T_VEC_WT;
            end
            S_T_VEC_WT: begin
                w_next = S_REDIR;
            end
            S_R_EPC_RD: begin
                w_req.en   = 1'b1;
                w_req.addr = ADDR_MEPC;
                w_next     = S_R_EPC_WT;
            end
            S_R_EPC_WT: begin
`ifdef MSTATUS_UPDATE_EN
                w_next = S_T_ST_RD;
`else
                w_next = S_REDIR;
`endif
            end
`ifdef MSTATUS_UPDATE_EN
            S_T_ST_RD: begin
                w_req.en   = 1'b1;
                w_req.addr = ADDR_MSTATUS;
                w_next     = S_T_ST_WT;
            end
            S_T_ST_WT: begin
                w_next = S_T_ST_WR;
            end
            S_T_ST_WR: begin
                w_req.en    = 1'b1;
                w_req.we    = 1'b1;
                w_req.addr  = ADDR_MSTATUS;
                w_req.wdata = w_mstatus_new;
                w_next      = r_is_trap ? S_T_VEC_RD : S_REDIR;
            end
`endif
            S_REDIR: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
        // A reset cycle must not touch storage, even mid-sequence
        if (reset) begin
            w_req = '0;
        end
    end

    // Done pulse, returned old value and redirect target
    always_ff @(posedge clk) begin
        if (reset) begin
            r_done           <= 1'b0;
            r_pipe_rdata     <= '0;
            r_redirect_pc    <= '0;
            r_redirect_valid <= 1'b0;
        end else begin
            r_done           <= w_done_nxt;
            r_redirect_valid <= (w_next == S_REDIR);
            if (w_take_x) begin
                r_pipe_rdata <= '0;
            end else if (r_state == S_P_WR) begin
                r_pipe_rdata <= bus.csr_rdata;
            end
            if (r_state == S_T_VEC_WT) begin
                r_redirect_pc <= align4(bus.csr_rdata);
            end else if (r_state == S_R_EPC_WT) begin
                r_redirect_pc <= bus.csr_rdata;
            end
        end
    end

`ifdef MSTATUS_UPDATE_EN
    // Remember which sequence owns the shared mstatus states; capture mstatus
    always_ff @(posedge clk) begin
        if (reset) begin
            r_is_trap <= 1'b0;
            r_mstatus <= '0;
        end else begin
            if (r_state == S_IDLE) begin
                r_is_trap <= bus.trap_req;
            end
            if (r_state == S_T_ST_WT) begin
                r_mstatus <= bus.csr_rdata;
            end
        end
    end
`endif

    assign bus.csr_en         = w_req.en;
    assign bus.csr_we         = w_req.we;
    assign bus.csr_addr       = w_req.addr;
    assign bus.csr_wdata      = w_req.wdata;
    assign bus.pipe_csr_done  = r_done;
    // Old value is live from storage during the write cycle, then held
    assign bus.pipe_csr_rdata = (r_state == S_P_WR) ? bus.csr_rdata : r_pipe_rdata;
    assign bus.redirect_valid = r_redirect_valid;
    assign bus.redirect_pc    = r_redirect_pc;
    assign bus.busy           = (r_state != S_IDLE) | bus.trap_req | bus.mret_req;

endmodule
